mem_wb_multi: RTL and testbench
===============================

// Module: mem_wb_multi
// PURPOSE
//  Parametrised MEM->WB pipeline boundary for a LANES-wide issue core. Registers LANES
//  write-back bundles {enable, addr, data} from the memory stage into the register file.
//  Provides a valid/ready handshake with a HOLD_DEPTH skid FIFO for a busy register-file
//  write port, stall/flush control, x0 write suppression, same-address lane merging and a
//  retired-write counter.
// PARAMETERS
//  LANES          2   write-back lanes per bundle
//  ADDR_W         5   register address width
//  DATA_W         32  register data width
//  STALL_W        3   width of stall_command
//  HOLD_DEPTH     2   skid FIFO entries (>=1)
//  STALL_ALL_CODE 5   stall_command value: flush the stage
//  STALL_HOLD_CODE 4  stall_command value: freeze the stage
// PORTS
//  clk           in   1              clock; all state updates on posedge
//  rst           in   1              asynchronous, active-low reset
//  rdy           in   1              global ready; 0 freezes all state
//  stall_command in   STALL_W        stage control code
//  mem_valid     in   1              bundle present from MEM
//  mem_ready     out  1              stage accepts bundle this cycle
//  mem_rd_enable in   LANES          per-lane write enable
//  mem_rd_addr   in   LANES*ADDR_W   per-lane dest reg; lane i at [i*ADDR_W +: ADDR_W]
//  mem_rd_data   in   LANES*DATA_W   per-lane write data
//  wb_valid      out  1              bundle presented to register file
//  reg_ready     in   1              register file takes the bundle this cycle
//  wb_rd_enable  out  LANES          per-lane write enable to reg
//  wb_rd_addr    out  LANES*ADDR_W   per-lane dest reg
//  wb_rd_data    out  LANES*DATA_W   per-lane data
//  retire_count  out  32             total lane writes delivered, wraps at 2^32
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, FIFO empty, retire_count=0.
//  - Priority each cycle: rst > ~rdy > STALL_ALL_CODE > STALL_HOLD_CODE > run.
//    Any other stall_command value is run.
//  - Input sanitising on accept: enable forced 0 where addr==0. If lanes i<j are both
//    enabled to the same addr, lane i enable is cleared; the higher lane wins.
//  - mem_ready = rdy & run & (fifo_count < HOLD_DEPTH). Accept = mem_valid & mem_ready.
//  - State: output register OUT (wb_valid + bundle), FIFO of HOLD_DEPTH bundles.
//  - Transfer = wb_valid & reg_ready in run. OUT is free if !wb_valid or transfer.
//  - Run, OUT free: load from FIFO head if non-empty (pop), else from the accepted input.
//    If nothing is loaded, wb_valid->0. An accept that does not go to OUT is pushed to FIFO.
//    Simultaneous pop+push keeps count. Order is strictly FIFO.
//  - Latency: accept into an empty stage -> wb_valid=1 the next cycle.
//  - Throughput: with reg_ready held at 1, one bundle per cycle.
//  - retire_count += popcount(wb_rd_enable) on each transfer; modulo 2^32.
//  - ~rdy: no state changes; mem_ready=0; outputs keep their values.
//  - STALL_ALL_CODE: OUT is cleared (wb_valid, enables, addr, data=0). FIFO is emptied.
//    Input is dropped; mem_ready=0; no transfer or count.
//  - STALL_HOLD_CODE: all state is frozen; mem_ready=0; wb_valid output masked to 0
//    combinationally. No write occurs and nothing is counted.
//  - FIFO full: mem_ready=0 even if a pop occurs the same cycle (no fall-through).
//  - Bundle with every enable 0 and mem_valid=1 still occupies a slot and transfers.
//    It adds 0 to retire_count.
//  - Async reset mid-operation drops OUT and FIFO contents immediately.
// TESTING
//  1. Reset: rst=0 with random inputs -> all outputs 0, mem_ready=0.
//     Release -> mem_ready=1, wb_valid=0.
//  2. Streaming with reg_ready=1: bundles {en=11,addr=(3,4),data=(A,B)} on consecutive
//     cycles -> each appears 1 cycle later; retire_count +2 per cycle.
//  3. Backpressure: reg_ready=0, send 4 bundles -> first in OUT, 2 in FIFO, mem_ready=0.
//     Then reg_ready=1 -> bundles emerge in order on 3 consecutive cycles.
//  4. Sanitising: lane0 addr=0 en=1 -> wb en[0]=0. Both lanes addr=7 data=(1,2) ->
//     only lane1 writes 2; retire_count +1.
//  5. Flush vs hold: STALL_HOLD_CODE with full FIFO -> wb_valid=0, contents preserved.
//     Then STALL_ALL_CODE -> wb_valid=0, FIFO empty, nothing emerges after run resumes.
//  6. rdy=0 for 3 cycles mid-stream -> outputs and retire_count unchanged. Resume ->
//     sequence continues with no loss or duplication. Counter wrap: preload via
//     2^32-1 writes (force) + 2 -> 1.

Source files
------------

// File: rtl/mem_wb_multi.sv
// MEM->WB pipeline boundary for a multi-lane core. One output register (OUT) presents a
// write-back bundle to the register file; a small skid FIFO absorbs bundles while the
// register-file port is busy. Handles stall/flush codes, x0 suppression, same-address lane
// merging (higher lane wins) and counts retired lane writes.
module mem_wb_multi #(
    parameter int unsigned LANES           = 2,
    parameter int unsigned ADDR_W          = 5,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned STALL_W         = 3,
    parameter int unsigned HOLD_DEPTH      = 2,
    parameter int unsigned STALL_ALL_CODE  = 5,
    parameter int unsigned STALL_HOLD_CODE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [STALL_W-1:0]        stall_command,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [LANES-1:0]          mem_rd_enable,
    input  logic [LANES*ADDR_W-1:0]   mem_rd_addr,
    input  logic [LANES*DATA_W-1:0]   mem_rd_data,
    output logic                      wb_valid,
    input  logic                      reg_ready,
    output logic [LANES-1:0]          wb_rd_enable,
    output logic [LANES*ADDR_W-1:0]   wb_rd_addr,
    output logic [LANES*DATA_W-1:0]   wb_rd_data,
    output logic [31:0]               retire_count
);

    localparam int unsigned AW   = LANES * ADDR_W;
    localparam int unsigned DW   = LANES * DATA_W;
    // Keep pointers at least one bit wide so HOLD_DEPTH == 1 still elaborates.
    localparam int unsigned PtrW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(HOLD_DEPTH + 1);

    // Output register
    logic                out_valid_q, out_valid_d;
    logic [LANES-1:0]    out_en_q, out_en_d;
    logic [AW-1:0]       out_addr_q, out_addr_d;
    logic [DW-1:0]       out_data_q, out_data_d;

    // Skid FIFO
    logic [LANES-1:0]    fifo_en_q   [HOLD_DEPTH];
    logic [AW-1:0]       fifo_addr_q [HOLD_DEPTH];
    logic [DW-1:0]       fifo_data_q [HOLD_DEPTH];
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [31:0]         retire_count_q, retire_count_d;

    logic                flush, hold, run;
    logic                accept, transfer, out_free, pop, push, load_in;
    logic [LANES-1:0]    in_en_clean;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(HOLD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
        logic [31:0] s;
        s = '0;
        for (int unsigned i = 0; i < LANES; i++) s = s + {31'd0, v[i]};
        return s;
    endfunction

    // Drop x0 writes and lower lanes shadowed by a higher lane to the same register.
    always_comb begin
        in_en_clean = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            in_en_clean[i] = mem_rd_enable[i] && (mem_rd_addr[i*ADDR_W +: ADDR_W] != '0);
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (mem_rd_enable[j] &&
                    (mem_rd_addr[j*ADDR_W +: ADDR_W] == mem_rd_addr[i*ADDR_W +: ADDR_W])) begin
                    in_en_clean[i] = 1'b0;
                end
            end
        end
    end

    // Handshake and movement decisions for this cycle.
    always_comb begin
        flush     = (stall_command == STALL_W'(STALL_ALL_CODE));
        hold      = !flush && (stall_command == STALL_W'(STALL_HOLD_CODE));
        run       = !flush && !hold;
        // Gated by rst so the port reads 0 while reset is held.
        mem_ready = rst && rdy && run && (cnt_q < CntW'(HOLD_DEPTH));
        accept    = mem_valid && mem_ready;
        transfer  = rdy && run && out_valid_q && reg_ready;
        out_free  = !out_valid_q || transfer;
        pop       = rdy && run && out_free && (cnt_q != '0);
        load_in   = accept && out_free && (cnt_q == '0);
        push      = accept && !load_in;
    end

    // Next-state for OUT, FIFO bookkeeping and the retire counter.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_en_d       = out_en_q;
        out_addr_d     = out_addr_q;
        out_data_d     = out_data_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        cnt_d          = cnt_q;
        retire_count_d = retire_count_q;
        if (rdy) begin
            if (flush) begin
                out_valid_d = 1'b0;
                out_en_d    = '0;
                out_addr_d  = '0;
                out_data_d  = '0;
                rd_ptr_d    = '0;
                wr_ptr_d    = '0;
                cnt_d       = '0;
            end else if (run) begin
                if (out_free) begin
                    if (pop) begin
                        out_valid_d = 1'b1;
                        out_en_d    = fifo_en_q[rd_ptr_q];
                        out_addr_d  = fifo_addr_q[rd_ptr_q];
                        out_data_d  = fifo_data_q[rd_ptr_q];
                    end else if (load_in) begin
                        out_valid_d = 1'b1;
                        out_en_d    = in_en_clean;
                        out_addr_d  = mem_rd_addr;
                        out_data_d  = mem_rd_data;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
                if (push) wr_ptr_d = next_ptr(wr_ptr_q);
                if (push && !pop) cnt_d = cnt_q + 1'b1;
                if (pop && !push) cnt_d = cnt_q - 1'b1;
                if (transfer) retire_count_d = retire_count_q + popcount(out_en_q);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q    <= 1'b0;
            out_en_q       <= '0;
            out_addr_q     <= '0;
            out_data_q     <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            cnt_q          <= '0;
            retire_count_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_en_q       <= out_en_d;
            out_addr_q     <= out_addr_d;
            out_data_q     <= out_data_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            cnt_q          <= cnt_d;
            retire_count_q <= retire_count_d;
        end
    end

    // FIFO storage; push already implies rdy and run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < HOLD_DEPTH; i++) begin
                fifo_en_q[i]   <= '0;
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push) begin
            fifo_en_q[wr_ptr_q]   <= in_en_clean;
            fifo_addr_q[wr_ptr_q] <= mem_rd_addr;
            fifo_data_q[wr_ptr_q] <= mem_rd_data;
        end
    end

    // Hold masks the valid combinationally; under ~rdy outputs simply keep their values.
    always_comb begin
        wb_valid     = out_valid_q && !(rdy && hold);
        wb_rd_enable = out_en_q;
        wb_rd_addr   = out_addr_q;
        wb_rd_data   = out_data_q;
        retire_count = retire_count_q;
    end

endmodule

// File: tb/tb_mem_wb_multi.sv
// Bench for mem_wb_multi: a queue-based model of the stage contents plus directed vectors.
module tb_mem_wb_multi;

    localparam int LANES = 2;
    localparam int DEPTH = 2;
    localparam logic [2:0] HOLD = 3'd4;
    localparam logic [2:0] ALL  = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy;
    logic [2:0]  stall_command;
    logic        mem_valid;
    logic        mem_ready;
    logic [1:0]  mem_rd_enable;
    logic [9:0]  mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        wb_valid;
    logic        reg_ready;
    logic [1:0]  wb_rd_enable;
    logic [9:0]  wb_rd_addr;
    logic [63:0] wb_rd_data;
    logic [31:0] retire_count;

    mem_wb_multi dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall_command(stall_command),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd_enable(mem_rd_enable),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .wb_valid     (wb_valid),
        .reg_ready    (reg_ready),
        .wb_rd_enable (wb_rd_enable),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_data   (wb_rd_data),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is an ordered list of bundles; the head is what the register file sees.
    typedef struct packed {
        logic [1:0]  en;
        logic [9:0]  addr;
        logic [63:0] data;
    } bundle_t;

    bundle_t     m_q[$];
    logic [31:0] m_cnt = '0;

    // Walk lanes from the top; the first lane to claim a non-zero register keeps its write.
    function automatic bundle_t sanitize(input logic [1:0] en, input logic [9:0] addr,
                                         input logic [63:0] data);
        bundle_t     b;
        logic [31:0] claimed;
        logic [4:0]  a;
        b.en = '0;
        b.addr = addr;
        b.data = data;
        claimed = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            a = addr[i*5 +: 5];
            if (en[i] && a != 5'd0 && !claimed[a]) begin
                b.en[i] = 1'b1;
                claimed[a] = 1'b1;
            end
        end
        return b;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_cnt = '0;
        end else if (rdy) begin
            if (stall_command == ALL) begin
                m_q.delete();
            end else if (stall_command != HOLD) begin
                if (mem_valid && m_q.size() <= DEPTH) begin
                    if (m_q.size() > 0 && reg_ready) begin
                        m_cnt = m_cnt + 32'($countones(m_q[0].en));
                        void'(m_q.pop_front());
                    end
                    m_q.push_back(sanitize(mem_rd_enable, mem_rd_addr, mem_rd_data));
                end else if (m_q.size() > 0 && reg_ready) begin
                    m_cnt = m_cnt + 32'($countones(m_q[0].en));
                    void'(m_q.pop_front());
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
            chk("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
            chk("rst_wb_en", {62'd0, wb_rd_enable}, 64'd0);
            chk("rst_wb_addr", {54'd0, wb_rd_addr}, 64'd0);
            chk("rst_wb_data", wb_rd_data, 64'd0);
            chk("rst_retire", {32'd0, retire_count}, 64'd0);
        end else begin
            chk("wb_valid", {63'd0, wb_valid},
                {63'd0, (m_q.size() > 0) && !(rdy && stall_command == HOLD)});
            chk("mem_ready", {63'd0, mem_ready},
                {63'd0, rdy && stall_command != HOLD && stall_command != ALL &&
                        (m_q.size() <= DEPTH)});
            chk("retire_count", {32'd0, retire_count}, {32'd0, m_cnt});
            if (m_q.size() > 0) begin
                chk("wb_en", {62'd0, wb_rd_enable}, {62'd0, m_q[0].en});
                chk("wb_addr", {54'd0, wb_rd_addr}, {54'd0, m_q[0].addr});
                chk("wb_data", wb_rd_data, m_q[0].data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_b(input logic v, input logic [1:0] en, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        mem_valid     = v;
        mem_rd_enable = en;
        mem_rd_addr   = {a1, a0};
        mem_rd_data   = {d1, d0};
    endtask

    initial begin
        // Reset with random inputs
        rst           = 1'b0;
        rdy           = 1'($urandom);
        stall_command = 3'($urandom);
        mem_valid     = 1'($urandom);
        mem_rd_enable = 2'($urandom);
        mem_rd_addr   = 10'($urandom);
        mem_rd_data   = {$urandom, $urandom};
        reg_ready     = 1'($urandom);
        repeat (3) cyc();
        chk("reset_mem_ready", {63'd0, mem_ready}, 64'd0);
        rdy = 1'b1; stall_command = 3'd0; mem_valid = 1'b0; reg_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("release_mem_ready", {63'd0, mem_ready}, 64'd1);
        chk("release_wb_valid", {63'd0, wb_valid}, 64'd0);

        // Streaming: each bundle visible one cycle after it is offered
        for (int k = 0; k < 4; k++) begin
            set_b(1'b1, 2'b11, 5'd3, 5'd4, 32'hA000_0000 + k, 32'hB000_0000 + k);
            cyc();
            chk("stream_data", {32'd0, wb_rd_data[31:0]}, {32'd0, 32'hA000_0000 + k});
        end
        set_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        repeat (3) cyc();
        chk("stream_count", {32'd0, retire_count}, 64'd8);

        // Backpressure: OUT plus two FIFO entries, fourth bundle refused
        reg_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_b(1'b1, 2'b11, 5'(k + 1), 5'(k + 9), 32'h100 + k, 32'h200 + k);
            cyc();
        end
        chk("bp_mem_ready", {63'd0, mem_ready}, 64'd0);
        set_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        reg_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_order", {32'd0, wb_rd_data[31:0]}, {32'd0, 32'h100 + k});
            cyc();
        end
        chk("bp_drained", {63'd0, wb_valid}, 64'd0);
        chk("bp_count", {32'd0, retire_count}, 64'd14);

        // Sanitising
        set_b(1'b1, 2'b11, 5'd0, 5'd5, 32'h11, 32'h22);
        cyc();
        chk("x0_en", {62'd0, wb_rd_enable}, 64'd2);
        set_b(1'b1, 2'b11, 5'd7, 5'd7, 32'd1, 32'd2);
        cyc();
        chk("merge_en", {62'd0, wb_rd_enable}, 64'd2);
        chk("merge_addr", {59'd0, wb_rd_addr[9:5]}, 64'd7);
        chk("merge_data", {32'd0, wb_rd_data[63:32]}, 64'd2);
        set_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        cyc();
        chk("merge_count", {32'd0, retire_count}, 64'd16);

        // Hold then flush with a full stage
        reg_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_b(1'b1, 2'b11, 5'(k + 1), 5'(k + 20), 32'h300 + k, 32'h400 + k);
            cyc();
        end
        set_b(1'b1, 2'b11, 5'd9, 5'd10, 32'h3FF, 32'h4FF);
        stall_command = HOLD;
        #1;
        chk("hold_valid", {63'd0, wb_valid}, 64'd0);
        repeat (2) cyc();
        chk("hold_keep", {32'd0, wb_rd_data[31:0]}, 64'h300);
        stall_command = ALL;
        cyc();
        chk("flush_valid", {63'd0, wb_valid}, 64'd0);
        chk("flush_en", {62'd0, wb_rd_enable}, 64'd0);
        chk("flush_data", wb_rd_data, 64'd0);
        stall_command = 3'd0;
        set_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        reg_ready = 1'b1;
        repeat (3) begin
            cyc();
            chk("post_flush_valid", {63'd0, wb_valid}, 64'd0);
        end
        chk("post_flush_count", {32'd0, retire_count}, 64'd16);

        // rdy=0 for three cycles mid-stream
        for (int k = 0; k < 8; k++) begin
            set_b(1'b1, 2'b11, 5'd3, 5'd4, 32'h500 + k, 32'h600 + k);
            if (k == 3) begin
                rdy = 1'b0;
                repeat (3) begin
                    cyc();
                    chk("rdy0_count", {32'd0, retire_count}, 64'd20);
                    chk("rdy0_data", {32'd0, wb_rd_data[31:0]}, 64'h502);
                end
                rdy = 1'b1;
            end
            cyc();
        end
        set_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        repeat (3) cyc();
        chk("rdy0_total", {32'd0, retire_count}, 64'd32);

        // Counter wrap
        force dut.retire_count_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        repeat (2) cyc();
        release dut.retire_count_q;
        set_b(1'b1, 2'b11, 5'd3, 5'd4, 32'h77, 32'h88);
        cyc();
        set_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        cyc();
        chk("wrap_count", {32'd0, retire_count}, 64'd1);

        // Async reset mid-operation
        reg_ready = 1'b0;
        set_b(1'b1, 2'b11, 5'd3, 5'd4, 32'h901, 32'h902);
        repeat (2) cyc();
        set_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        rst = 1'b0;
        #1;
        chk("arst_valid", {63'd0, wb_valid}, 64'd0);
        chk("arst_count", {32'd0, retire_count}, 64'd0);
        cyc();
        rst = 1'b1;
        reg_ready = 1'b1;
        repeat (2) cyc();
        chk("arst_empty", {63'd0, wb_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
